fpadd_swap_diff: RTL and testbench

Front-end stage of the floating-point adder. It compares the magnitudes of two operands, swaps them so the larger comes first, and computes the exponent difference. It also builds the two's-complement significand of the smaller operand. Its outputs `fA` and `n` feed the alignment shifter (`fpadd_shift`) directly; `fB`, `eR`, `sR`, `excR` and `eff_sub` travel alongside to the significand adder. It is a 2-stage pipeline with a valid/ready handshake.

---
 rtl/fpadd_swap_diff.sv | 179 +++++++++++++++++
 tb/tb_fpadd_swap_diff.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_swap_diff.sv
// Floating-point adder front end: orders the operands by magnitude, computes the
// exponent difference and prepares both significands for alignment and addition.
module fpadd_swap_diff #(
  parameter int wE = 4,
  parameter int wF = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [wE+wF+2:0]     X,
  input  logic [wE+wF+2:0]     Y,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [wF+1:0]        fA,
  output logic [wE-1:0]        n,
  output logic [wF+1:0]        fB,
  output logic [wE-1:0]        eR,
  output logic                 sR,
  output logic [1:0]           excR,
  output logic                 eff_sub
);

  localparam int W = wE + wF + 3;
  localparam int S = wF + 2;

  logic en;

  // operand fields, index 0 = X, index 1 = Y
  logic [W-1:0]  op_in  [2];
  logic [1:0]    exc_in [2];
  logic          s_in   [2];
  logic [wE-1:0] e_in   [2];
  logic [wF-1:0] f_in   [2];
  logic [S-1:0]  sig_in [2];

  logic          v1_reg;
  logic          swap_reg;
  logic [wE-1:0] diff_reg;
  logic          sub1_reg;
  logic [1:0]    exc1_reg [2];
  logic          s1_reg   [2];
  logic [wE-1:0] e1_reg   [2];
  logic [S-1:0]  sig1_reg [2];

  logic [1:0]    is_nan;
  logic [1:0]    is_inf;
  logic [1:0]    is_norm;

  logic          swap_next;
  logic [wE-1:0] diff_xy;
  logic [wE-1:0] diff_yx;
  logic [wE-1:0] diff_next;
  logic          sub_next;

  logic          lg;
  logic [S-1:0]  sig_s;
  logic [S-1:0]  fa_next;
  logic [1:0]    excr_next;
  logic          sr_next;

  logic          out_valid_reg;
  logic [S-1:0]  fa_reg;
  logic [wE-1:0] n_reg;
  logic [S-1:0]  fb_reg;
  logic [wE-1:0] er_reg;
  logic          sr_reg;
  logic [1:0]    excr_reg;
  logic          eff_sub_reg;

  assign en       = !out_valid_reg | out_ready;
  assign in_ready = en;

  assign op_in[0] = X;
  assign op_in[1] = Y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign exc_in[gi] = op_in[gi][W-1:W-2];
      assign s_in[gi]   = op_in[gi][W-3];
      assign e_in[gi]   = op_in[gi][wE+wF-1:wF];
      assign f_in[gi]   = op_in[gi][wF-1:0];
      // only normal numbers carry the implicit leading one
      assign sig_in[gi] = {1'b0, (op_in[gi][W-1:W-2] == 2'b01), op_in[gi][wF-1:0]};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          exc1_reg[gi] <= '0;
          s1_reg[gi]   <= 1'b0;
          e1_reg[gi]   <= '0;
          sig1_reg[gi] <= '0;
        end else if (en) begin
          exc1_reg[gi] <= exc_in[gi];
          s1_reg[gi]   <= s_in[gi];
          e1_reg[gi]   <= e_in[gi];
          sig1_reg[gi] <= sig_in[gi];
        end
      end

      assign is_nan[gi]  = (exc1_reg[gi] == 2'b11);
      assign is_inf[gi]  = (exc1_reg[gi] == 2'b10);
      assign is_norm[gi] = (exc1_reg[gi] == 2'b01);
    end
  endgenerate

  // ties keep X as the larger operand
  assign swap_next = {e_in[1], f_in[1]} > {e_in[0], f_in[0]};
  assign diff_xy   = e_in[0] - e_in[1];
  assign diff_yx   = e_in[1] - e_in[0];
  assign diff_next = swap_next ? diff_yx : diff_xy;
  assign sub_next  = s_in[0] ^ s_in[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      swap_reg <= 1'b0;
      diff_reg <= '0;
      sub1_reg <= 1'b0;
    end else if (en) begin
      v1_reg   <= in_valid;
      swap_reg <= swap_next;
      diff_reg <= diff_next;
      sub1_reg <= sub_next;
    end
  end

  assign lg      = swap_reg;
  assign sig_s   = sig1_reg[~lg];
  assign fa_next = sub1_reg ? -sig_s : sig_s;

  always_comb begin
    excr_next = 2'b00;
    sr_next   = s1_reg[lg];
    if ((|is_nan) || (is_inf[0] && is_inf[1] && sub1_reg)) begin
      excr_next = 2'b11;
    end else if (|is_inf) begin
      // the infinity dictates the sign even when it is the "smaller" encoding
      excr_next = 2'b10;
      sr_next   = is_inf[0] ? s1_reg[0] : s1_reg[1];
    end else if (|is_norm) begin
      excr_next = 2'b01;
    end else begin
      sr_next   = s1_reg[0] & s1_reg[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      fa_reg        <= '0;
      n_reg         <= '0;
      fb_reg        <= '0;
      er_reg        <= '0;
      sr_reg        <= 1'b0;
      excr_reg      <= 2'b00;
      eff_sub_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= v1_reg;
      fa_reg        <= fa_next;
      n_reg         <= diff_reg;
      fb_reg        <= sig1_reg[lg];
      er_reg        <= e1_reg[lg];
      sr_reg        <= sr_next;
      excr_reg      <= excr_next;
      eff_sub_reg   <= sub1_reg;
    end
  end

  assign out_valid = out_valid_reg;
  assign fA        = fa_reg;
  assign n         = n_reg;
  assign fB        = fb_reg;
  assign eR        = er_reg;
  assign sR        = sr_reg;
  assign excR      = excr_reg;
  assign eff_sub   = eff_sub_reg;

endmodule

// File: tb/tb_fpadd_swap_diff.sv
// Scoreboard bench for fpadd_swap_diff: directed cases, backpressure, mid-stream
// reset and randomized traffic against an arithmetic reference model.
module tb_fpadd_swap_diff;

  typedef struct packed {
    logic [6:0] fa;
    logic [3:0] n;
    logic [6:0] fb;
    logic [3:0] er;
    logic       sr;
    logic [1:0] exc;
    logic       es;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] X = '0;
  logic [11:0] Y = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  fA;
  logic [3:0]  n;
  logic [6:0]  fB;
  logic [3:0]  eR;
  logic        sR;
  logic [1:0]  excR;
  logic        eff_sub;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  res_t cur_exp;
  res_t prev_res;
  logic stalled_prev = 1'b0;
  res_t dut_res;
  bit   rnd_done;

  assign dut_res = {fA, n, fB, eR, sR, excR, eff_sub};

  always #5 clk = ~clk;

  fpadd_swap_diff #(.wE(4), .wF(5)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .fA(fA), .n(n), .fB(fB), .eR(eR), .sR(sR), .excR(excR), .eff_sub(eff_sub)
  );

  // reference: pick the larger magnitude numerically, then apply the result rules
  function automatic res_t model(input logic [11:0] x, input logic [11:0] y);
    res_t r;
    int ex, ey, fx, fy, sigx, sigy, sigs;
    logic [1:0] cx, cy;
    logic sx, sy;
    bit swap;
    cx = x[11:10]; sx = x[9]; ex = int'(x[8:5]); fx = int'(x[4:0]);
    cy = y[11:10]; sy = y[9]; ey = int'(y[8:5]); fy = int'(y[4:0]);
    sigx = (cx == 2'b01 ? 32 : 0) + fx;
    sigy = (cy == 2'b01 ? 32 : 0) + fy;
    swap = (ey * 32 + fy) > (ex * 32 + fx);
    sigs = swap ? sigx : sigy;
    r.es  = sx ^ sy;
    r.n   = 4'(swap ? ey - ex : ex - ey);
    r.er  = 4'(swap ? ey : ex);
    r.fb  = 7'(swap ? sigy : sigx);
    r.fa  = r.es ? 7'((128 - sigs) % 128) : 7'(sigs);
    r.sr  = swap ? sy : sx;
    if (cx == 2'b11 || cy == 2'b11 || (cx == 2'b10 && cy == 2'b10 && r.es)) begin
      r.exc = 2'b11;
    end else if (cx == 2'b10 || cy == 2'b10) begin
      r.exc = 2'b10;
      r.sr  = (cx == 2'b10) ? sx : sy;
    end else if (cx == 2'b01 || cy == 2'b01) begin
      r.exc = 2'b01;
    end else begin
      r.exc = 2'b00;
      r.sr  = sx & sy;
    end
    return r;
  endfunction

  task automatic report(input string name, input res_t got, input res_t exp);
    $display("FAIL %s: got fA=%h n=%0d fB=%h eR=%0d sR=%b excR=%b eff_sub=%b, want fA=%h n=%0d fB=%h eR=%0d sR=%b excR=%b eff_sub=%b",
             name, got.fa, got.n, got.fb, got.er, got.sr, got.exc, got.es,
             exp.fa, exp.n, exp.fb, exp.er, exp.sr, exp.exc, exp.es);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // monitor: hold check, scoreboard pop on output handshake, push on input handshake
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || dut_res !== prev_res) begin
          failures++;
          report("stall_hold", dut_res, prev_res);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got fA=%h n=%0d with empty scoreboard", fA, n);
        end else begin
          res_t e;
          e = sb.pop_front();
          if (dut_res !== e) begin
            failures++;
            report("result", dut_res, e);
          end
        end
      end
      stalled_prev = out_valid && !out_ready;
      prev_res = dut_res;
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic send(input logic [11:0] x, input logic [11:0] y, input res_t e);
    bit ok;
    X = x; Y = y; cur_exp = e; in_valid = 1'b1; ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 64 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end
  endtask

  logic [11:0] dx [7];
  logic [11:0] dy [7];
  res_t        dexp [7];

  initial begin
    dx[0] = 12'h530; dy[0] = 12'h4C8; dexp[0] = {7'h28, 4'd3, 7'h30, 4'd9, 1'b0, 2'b01, 1'b0};
    dx[1] = 12'h4C8; dy[1] = 12'h730; dexp[1] = {7'h58, 4'd3, 7'h30, 4'd9, 1'b1, 2'b01, 1'b1};
    dx[2] = 12'h530; dy[2] = 12'h730; dexp[2] = {7'h50, 4'd0, 7'h30, 4'd9, 1'b0, 2'b01, 1'b1};
    dx[3] = 12'h530; dy[3] = 12'h000; dexp[3] = {7'h00, 4'd9, 7'h30, 4'd9, 1'b0, 2'b01, 1'b0};
    dx[4] = 12'h800; dy[4] = 12'hA00; dexp[4] = {7'h00, 4'd0, 7'h00, 4'd0, 1'b0, 2'b11, 1'b1};
    dx[5] = 12'h800; dy[5] = 12'h4C8; dexp[5] = {7'h00, 4'd6, 7'h28, 4'd6, 1'b0, 2'b10, 1'b0};
    dx[6] = 12'h000; dy[6] = 12'h200; dexp[6] = {7'h00, 4'd0, 7'h00, 4'd0, 1'b0, 2'b00, 1'b1};

    // asynchronous reset with no clock edge
    #1 rst = 1'b1;
    #2;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    checks++;
    if (dut_res !== '0) begin failures++; report("reset_outputs", dut_res, '0); end
    #5 rst = 1'b0;

    // first transaction: latency of two edges
    @(posedge clk); #1;
    send(dx[0], dy[0], dexp[0]);
    check_bit("latency_edge1", out_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("latency_edge2", out_valid, 1'b1);
    for (int i = 1; i < 7; i++) send(dx[i], dy[i], dexp[i]);
    drain();

    // backpressure: four back-to-back inputs, consumer stalls for three cycles
    fork
      for (int i = 0; i < 4; i++) send(dx[i], dy[i], dexp[i]);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_bit("stall_in_ready", in_ready, 1'b0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two transactions in flight
    send(dx[1], dy[1], dexp[1]);
    send(dx[2], dy[2], dexp[2]);
    #1 rst = 1'b1;
    #1;
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_bit("midreset_in_ready", in_ready, 1'b1);
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send(dx[5], dy[5], dexp[5]);
    check_bit("post_reset_edge1", out_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("post_reset_edge2", out_valid, 1'b1);
    drain();

    // randomized traffic with random consumer stalls
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [11:0] rx, ry;
          int idle;
          idle = $urandom_range(0, 2);
          repeat (idle) begin @(posedge clk); #1; end
          rx = 12'($urandom);
          ry = 12'($urandom);
          send(rx, ry, model(rx, ry));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running want finished");
    $fatal(1, "timeout");
  end

endmodule
